// File: rtl/rs75_error_corrector.sv
// RS(7,5) single-symbol error corrector over GF(8), p(x)=x^3+x+1.
// Each SEARCH cycle tests one error position, so the latency depends on where the error sits.
module rs75_error_corrector #(
  parameter int N            = 7,
  parameter int K            = 5,
  parameter int SYMBOL_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N*SYMBOL_WIDTH-1:0]   v,
  input  logic [SYMBOL_WIDTH-1:0]     s1,
  input  logic [SYMBOL_WIDTH-1:0]     s2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N*SYMBOL_WIDTH-1:0]   c,
  output logic [K*SYMBOL_WIDTH-1:0]   data_out,
  output logic                        err_corrected,
  output logic                        err_uncorrectable,
  output logic [2:0]                  err_pos
);

  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

  state_t                       state_q, state_d;
  logic [N*SYMBOL_WIDTH-1:0]    word_q, word_d;
  logic [SYMBOL_WIDTH-1:0]      syn2_q, syn2_d;
  logic [SYMBOL_WIDTH-1:0]      tVal_q, tVal_d;
  logic [SYMBOL_WIDTH-1:0]      uVal_q, uVal_d;
  logic [2:0]                   idx_q, idx_d;
  logic                         corrected_q, corrected_d;
  logic                         uncorrectable_q, uncorrectable_d;
  logic [2:0]                   pos_q, pos_d;

  function automatic logic [2:0] mulAlpha(input logic [2:0] x);
    return {x[1], x[0] ^ x[2], x[2]};
  endfunction

  // alpha^6 == alpha^-1, which reduces to a rotate with one feedback xor
  function automatic logic [2:0] mulAlphaInv(input logic [2:0] x);
    return {x[0], x[2], x[1] ^ x[0]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      word_q          <= '0;
      syn2_q          <= '0;
      tVal_q          <= '0;
      uVal_q          <= '0;
      idx_q           <= '0;
      corrected_q     <= 1'b0;
      uncorrectable_q <= 1'b0;
      pos_q           <= '0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      syn2_q          <= syn2_d;
      tVal_q          <= tVal_d;
      uVal_q          <= uVal_d;
      idx_q           <= idx_d;
      corrected_q     <= corrected_d;
      uncorrectable_q <= uncorrectable_d;
      pos_q           <= pos_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    syn2_d          = syn2_q;
    tVal_d          = tVal_q;
    uVal_d          = uVal_q;
    idx_d           = idx_q;
    corrected_d     = corrected_q;
    uncorrectable_d = uncorrectable_q;
    pos_d           = pos_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d          = v;
          syn2_d          = s2;
          tVal_d          = s1;
          uVal_d          = s1;
          idx_d           = '0;
          corrected_d     = 1'b0;
          uncorrectable_d = 1'b0;
          pos_d           = '0;
          if (s1 == '0 && s2 == '0) begin
            state_d = OUT;
          end else if (s1 == '0 || s2 == '0) begin
            uncorrectable_d = 1'b1;
            state_d         = OUT;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        // T = s1*a^k meets s2 exactly at the error position; U then holds the error value
        if (tVal_q == syn2_q) begin
          word_d[int'(idx_q)*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
            word_q[int'(idx_q)*SYMBOL_WIDTH +: SYMBOL_WIDTH] ^ uVal_q;
          corrected_d = 1'b1;
          pos_d       = idx_q;
          state_d     = OUT;
        end else if (idx_q == 3'd6) begin
          uncorrectable_d = 1'b1;
          state_d         = OUT;
        end else begin
          idx_d  = idx_q + 3'd1;
          tVal_d = mulAlpha(tVal_q);
          uVal_d = mulAlphaInv(uVal_q);
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready          = (state_q == IDLE);
  assign out_valid         = (state_q == OUT);
  assign c                 = word_q;
  assign data_out          = word_q[N*SYMBOL_WIDTH-1 -: K*SYMBOL_WIDTH];
  assign err_corrected     = corrected_q;
  assign err_uncorrectable = uncorrectable_q;
  assign err_pos           = pos_q;

endmodule

// File: tb/tb_rs75_error_corrector.sv
// Directed-vector bench for rs75_error_corrector: table of words with known syndromes,
// plus backpressure and mid-search reset sequences.
module tb_rs75_error_corrector;

  typedef struct packed {
    logic [20:0] v;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [20:0] expC;
    logic        expCorr;
    logic        expUnc;
    logic [2:0]  expPos;
    logic [7:0]  expLat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] v = '0;
  logic [2:0]  s1 = '0;
  logic [2:0]  s2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [20:0] c;
  logic [14:0] data_out;
  logic        err_corrected;
  logic        err_uncorrectable;
  logic [2:0]  err_pos;

  int total = 0;
  int bad   = 0;
  vec_t vecs[9];

  rs75_error_corrector dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .v(v), .s1(s1), .s2(s2),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .data_out(data_out),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
    .err_pos(err_pos)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [20:0] vv, input logic [2:0] a, input logic [2:0] b,
                                 input logic [20:0] ec, input logic corr, input logic unc,
                                 input logic [2:0] pos, input logic [7:0] lat);
    vec_t t;
    t.v = vv; t.s1 = a; t.s2 = b; t.expC = ec;
    t.expCorr = corr; t.expUnc = unc; t.expPos = pos; t.expLat = lat;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Present a word, wait for the result, check it and pop it with out_ready.
  task automatic applyStimulus(input vec_t t, input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    in_valid = 1'b1; v = t.v; s1 = t.s1; s2 = t.s2; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    checkOutput({tag, " out_valid seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, " latency"}, n + 1, 32'(t.expLat));
      checkOutput({tag, " c"}, 32'(c), 32'(t.expC));
      checkOutput({tag, " data_out"}, 32'(data_out), 32'(t.expC[20:6]));
      checkOutput({tag, " err_corrected"}, 32'(err_corrected), 32'(t.expCorr));
      checkOutput({tag, " err_uncorrectable"}, 32'(err_uncorrectable), 32'(t.expUnc));
      checkOutput({tag, " err_pos"}, 32'(err_pos), 32'(t.expPos));
      checkOutput({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after pop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after pop"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Codeword g(x)=x^2+a^4x+a^3 -> symbols {3,6,1} = 0x073; x*g(x) -> 0x398
    vecs[0] = mkVec(21'h000000, 3'd0, 3'd0, 21'h000000, 1'b0, 1'b0, 3'd0, 8'd1);
    vecs[1] = mkVec(21'h000200, 3'd3, 3'd5, 21'h000000, 1'b1, 1'b0, 3'd3, 8'd5);
    vecs[2] = mkVec(21'h000002, 3'd2, 3'd2, 21'h000000, 1'b1, 1'b0, 3'd0, 8'd2);
    vecs[3] = mkVec(21'h040000, 3'd5, 3'd7, 21'h000000, 1'b1, 1'b0, 3'd6, 8'd8);
    vecs[4] = mkVec(21'h020073, 3'd1, 3'd7, 21'h000073, 1'b1, 1'b0, 3'd5, 8'd7);
    vecs[5] = mkVec(21'h000398, 3'd0, 3'd0, 21'h000398, 1'b0, 1'b0, 3'd0, 8'd1);
    vecs[6] = mkVec(21'h012345, 3'd3, 3'd0, 21'h012345, 1'b0, 1'b1, 3'd0, 8'd1);
    vecs[7] = mkVec(21'h000ABC, 3'd0, 3'd4, 21'h000ABC, 1'b0, 1'b1, 3'd0, 8'd1);
    vecs[8] = mkVec(21'h00004B, 3'd5, 3'd1, 21'h000073, 1'b1, 1'b0, 3'd1, 8'd3);

    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset c", 32'(c), 32'd0);
    checkOutput("reset err_corrected", 32'(err_corrected), 32'd0);
    checkOutput("reset err_uncorrectable", 32'(err_uncorrectable), 32'd0);
    checkOutput("reset err_pos", 32'(err_pos), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: error at j=3, then hold the result while a second word waits upstream
    begin
      int n;
      @(negedge clk);
      in_valid = 1'b1; v = 21'h000200; s1 = 3'd3; s2 = 3'd5;
      @(posedge clk); #1;
      v = 21'h000398; s1 = 3'd0; s2 = 3'd0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("bp reached OUT", 32'(out_valid), 32'd1);
      checkOutput("bp latency", n + 1, 32'd5);
      for (int cyc = 0; cyc < 4; cyc++) begin
        @(posedge clk); #1;
        checkOutput($sformatf("bp hold%0d out_valid", cyc), 32'(out_valid), 32'd1);
        checkOutput($sformatf("bp hold%0d in_ready", cyc), 32'(in_ready), 32'd0);
        checkOutput($sformatf("bp hold%0d c", cyc), 32'(c), 32'd0);
        checkOutput($sformatf("bp hold%0d err_pos", cyc), 32'(err_pos), 32'd3);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp idle in_ready", 32'(in_ready), 32'd1);
      checkOutput("bp idle out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp second out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp second c", 32'(c), 32'h398);
      checkOutput("bp second err_corrected", 32'(err_corrected), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    // Reset while searching for j=6, then a clean j=3 word must still take the full search
    @(negedge clk);
    in_valid = 1'b1; v = 21'h040000; s1 = 3'd5; s2 = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(vecs[1], "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
